log_rs: RTL and testbench



---
 rtl/ppc_types.sv | 19 +
 rtl/rs_select.sv | 15 +
 rtl/log_rs.sv | 116 +++++++++++
 tb/tb_log_rs.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ppc_types.sv
// ppc_types: shared decode, reservation-station state and entry types
package ppc_types;
  typedef enum logic [2:0] {LOG_AND, LOG_OR, LOG_XOR, LOG_NAND, LOG_NOR, LOG_EQV, LOG_ANDC, LOG_ORC} log_decode_t;
  typedef enum logic [1:0] {RS_FREE, RS_WAITING, RS_READY, RS_ISSUED} rs_state_t;
  // Entry tags are stored at the widest supported rs_id width; users compare the low RS_ID_WIDTH bits.
  localparam int RS_TAG_MAX_W = 8;
  typedef logic [RS_TAG_MAX_W-1:0] rs_tag_t;
  typedef struct packed {
    rs_state_t   state;
    logic [31:0] op1_value;
    logic [31:0] op2_value;
    logic        op1_valid;
    logic        op2_valid;
    rs_tag_t     op1_tag;
    rs_tag_t     op2_tag;
    log_decode_t control;
    logic [4:0]  result_reg_addr;
  } log_rs_entry_t;
endpackage

// File: rtl/rs_select.sv
// rs_select: lowest-set-bit priority encoder with found flag
module rs_select #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);
  always_comb begin
    found = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = req[i] ? W'(i) : idx;
  end
endmodule

// File: rtl/log_rs.sv
// log_rs: reservation station and issue scheduler feeding log_unit
module log_rs import ppc_types::*; #(
  parameter int RS_ID_WIDTH = 5,
  parameter int RS_OFFSET   = 0,
  parameter int NUM_ENTRIES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dispatch_valid,
  output logic                   dispatch_ready,
  input  logic [31:0]            dispatch_op1_value,
  input  logic                   dispatch_op1_valid,
  input  logic [RS_ID_WIDTH-1:0] dispatch_op1_tag,
  input  logic [31:0]            dispatch_op2_value,
  input  logic                   dispatch_op2_valid,
  input  logic [RS_ID_WIDTH-1:0] dispatch_op2_tag,
  input  log_decode_t            dispatch_control,
  input  logic [4:0]             dispatch_result_reg_addr,
  input  logic                   cdb_valid,
  input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
  input  logic [31:0]            cdb_result,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [RS_ID_WIDTH-1:0] issue_rs_id,
  output logic [4:0]             issue_result_reg_addr,
  output logic [31:0]            issue_op1,
  output logic [31:0]            issue_op2,
  output log_decode_t            issue_control
);
  localparam int IW = $clog2(NUM_ENTRIES);
  log_rs_entry_t e [NUM_ENTRIES];
  log_rs_entry_t e_nxt [NUM_ENTRIES];
  log_rs_entry_t d;
  logic [NUM_ENTRIES-1:0] free_vec, ready_vec;
  logic free_found, ready_found, lock_valid, dispatch_fire, issue_fire;
  logic [IW-1:0] free_idx, ready_idx, lock_idx, sel_idx;
  logic [RS_ID_WIDTH-1:0] h_rs_id;
  logic [4:0] h_addr;
  logic [31:0] h_op1, h_op2;
  log_decode_t h_control;
  always_comb begin
    free_vec = '0;
    ready_vec = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      free_vec[i] = e[i].state == RS_FREE;
      ready_vec[i] = e[i].state == RS_READY;
    end
  end
  rs_select #(.N(NUM_ENTRIES), .W(IW)) u_free (.req(free_vec), .found(free_found), .idx(free_idx));
  rs_select #(.N(NUM_ENTRIES), .W(IW)) u_ready (.req(ready_vec), .found(ready_found), .idx(ready_idx));
  assign dispatch_ready = free_found;
  assign dispatch_fire = dispatch_valid & free_found;
  // A stalled offer stays pinned to its entry until log_unit takes it.
  assign sel_idx = lock_valid ? lock_idx : ready_idx;
  assign issue_valid = lock_valid | ready_found;
  assign issue_fire = issue_valid & issue_ready;
  assign issue_rs_id = issue_valid ? RS_ID_WIDTH'(RS_OFFSET + int'(sel_idx)) : h_rs_id;
  assign issue_result_reg_addr = issue_valid ? e[sel_idx].result_reg_addr : h_addr;
  assign issue_op1 = issue_valid ? e[sel_idx].op1_value : h_op1;
  assign issue_op2 = issue_valid ? e[sel_idx].op2_value : h_op2;
  assign issue_control = issue_valid ? e[sel_idx].control : h_control;
  always_comb begin
    d = '0;
    d.op1_valid = dispatch_op1_valid | (cdb_valid & (dispatch_op1_tag == cdb_rs_id));
    d.op2_valid = dispatch_op2_valid | (cdb_valid & (dispatch_op2_tag == cdb_rs_id));
    d.op1_value = dispatch_op1_valid ? dispatch_op1_value : cdb_result;
    d.op2_value = dispatch_op2_valid ? dispatch_op2_value : cdb_result;
    d.op1_tag = rs_tag_t'(dispatch_op1_tag);
    d.op2_tag = rs_tag_t'(dispatch_op2_tag);
    d.control = dispatch_control;
    d.result_reg_addr = dispatch_result_reg_addr;
    d.state = (d.op1_valid & d.op2_valid) ? RS_READY : RS_WAITING;
  end
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      e_nxt[i] = e[i];
      if (e[i].state == RS_WAITING) begin
        if (!e[i].op1_valid && cdb_valid && e[i].op1_tag[RS_ID_WIDTH-1:0] == cdb_rs_id) begin
          e_nxt[i].op1_value = cdb_result;
          e_nxt[i].op1_valid = 1'b1;
        end
        if (!e[i].op2_valid && cdb_valid && e[i].op2_tag[RS_ID_WIDTH-1:0] == cdb_rs_id) begin
          e_nxt[i].op2_value = cdb_result;
          e_nxt[i].op2_valid = 1'b1;
        end
        e_nxt[i].state = (e_nxt[i].op1_valid & e_nxt[i].op2_valid) ? RS_READY : RS_WAITING;
      end
      if (e[i].state == RS_READY && issue_fire && sel_idx == IW'(i)) e_nxt[i].state = RS_ISSUED;
      if (e[i].state == RS_ISSUED && cdb_valid && cdb_rs_id == RS_ID_WIDTH'(RS_OFFSET + i)) e_nxt[i].state = RS_FREE;
      if (e[i].state == RS_FREE && dispatch_fire && free_idx == IW'(i)) e_nxt[i] = d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) e[i] <= '0;
      lock_valid <= 1'b0;
      lock_idx <= '0;
      h_rs_id <= '0;
      h_addr <= '0;
      h_op1 <= '0;
      h_op2 <= '0;
      h_control <= LOG_AND;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) e[i] <= e_nxt[i];
      lock_valid <= issue_valid & ~issue_ready;
      lock_idx <= sel_idx;
      if (issue_valid) begin
        h_rs_id <= issue_rs_id;
        h_addr <= issue_result_reg_addr;
        h_op1 <= issue_op1;
        h_op2 <= issue_op2;
        h_control <= issue_control;
      end
    end
  end
endmodule

// File: tb/tb_log_rs.sv
// tb_log_rs: directed vector table plus randomized run against a reference model
module tb_log_rs;
  import ppc_types::*;
  logic clk = 1'b0, rst = 1'b1;
  logic dispatch_valid = 0, dispatch_ready;
  logic [31:0] dispatch_op1_value = 0, dispatch_op2_value = 0;
  logic dispatch_op1_valid = 0, dispatch_op2_valid = 0;
  logic [4:0] dispatch_op1_tag = 0, dispatch_op2_tag = 0, dispatch_result_reg_addr = 0;
  log_decode_t dispatch_control = LOG_AND;
  logic cdb_valid = 0;
  logic [4:0] cdb_rs_id = 0;
  logic [31:0] cdb_result = 0;
  logic issue_valid, issue_ready = 0;
  logic [4:0] issue_rs_id, issue_result_reg_addr;
  logic [31:0] issue_op1, issue_op2;
  log_decode_t issue_control;
  always #5 clk = ~clk;
  log_rs dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_op1_value(dispatch_op1_value), .dispatch_op1_valid(dispatch_op1_valid), .dispatch_op1_tag(dispatch_op1_tag),
    .dispatch_op2_value(dispatch_op2_value), .dispatch_op2_valid(dispatch_op2_valid), .dispatch_op2_tag(dispatch_op2_tag),
    .dispatch_control(dispatch_control), .dispatch_result_reg_addr(dispatch_result_reg_addr),
    .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_result(cdb_result),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rs_id(issue_rs_id),
    .issue_result_reg_addr(issue_result_reg_addr), .issue_op1(issue_op1), .issue_op2(issue_op2),
    .issue_control(issue_control)
  );
  int total = 0, bad = 0;
  task automatic chk(string n, logic [31:0] a, logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", n, a, x);
    end
  endtask
  typedef struct {
    logic dv; logic [31:0] o1; logic p1; logic [4:0] t1; logic [31:0] o2; logic p2; logic [4:0] t2;
    logic cv; logic [4:0] ct; logic [31:0] cr; logic ir;
    logic xdr; logic xiv; logic [4:0] xid; logic [31:0] xo1; logic [31:0] xo2;
  } vec_t;
  vec_t tab[$];
  task automatic r(logic dv, logic [31:0] o1, logic p1, logic [4:0] t1, logic [31:0] o2, logic p2, logic [4:0] t2,
                   logic cv, logic [4:0] ct, logic [31:0] cr, logic ir,
                   logic xdr, logic xiv, logic [4:0] xid, logic [31:0] xo1, logic [31:0] xo2);
    vec_t v;
    v = '{dv, o1, p1, t1, o2, p2, t2, cv, ct, cr, ir, xdr, xiv, xid, xo1, xo2};
    tab.push_back(v);
  endtask
  task automatic idle();
    dispatch_valid = 0; cdb_valid = 0; issue_ready = 0;
  endtask
  localparam int M_FREE = 0, M_WAIT = 1, M_READY = 2, M_ISSUED = 3;
  int mst[4], lock;
  logic [31:0] m1[4], m2[4], h1, h2;
  logic mp1[4], mp2[4];
  logic [4:0] mt1[4], mt2[4], mad[4], hid, had;
  log_decode_t mc[4], hc;
  task automatic model_reset();
    for (int i = 0; i < 4; i++) mst[i] = M_FREE;
    lock = -1; h1 = 0; h2 = 0; hid = 0; had = 0; hc = LOG_AND;
  endtask
  task automatic model_step();
    int fr, sel;
    fr = -1; sel = lock;
    for (int i = 3; i >= 0; i--) begin
      if (mst[i] == M_FREE) fr = i;
      if (lock < 0 && mst[i] == M_READY) sel = i;
    end
    chk("dispatch_ready", dispatch_ready, fr >= 0);
    chk("issue_valid", issue_valid, sel >= 0);
    if (sel >= 0) begin
      hid = 5'(sel); had = mad[sel]; h1 = m1[sel]; h2 = m2[sel]; hc = mc[sel];
    end
    chk("issue_rs_id", issue_rs_id, hid);
    chk("issue_addr", issue_result_reg_addr, had);
    chk("issue_op1", issue_op1, h1);
    chk("issue_op2", issue_op2, h2);
    chk("issue_control", issue_control, hc);
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 4; i++) begin
      if (mst[i] == M_WAIT) begin
        if (!mp1[i] && cdb_valid && cdb_rs_id == mt1[i]) begin m1[i] = cdb_result; mp1[i] = 1; end
        if (!mp2[i] && cdb_valid && cdb_rs_id == mt2[i]) begin m2[i] = cdb_result; mp2[i] = 1; end
        if (mp1[i] && mp2[i]) mst[i] = M_READY;
      end else if (mst[i] == M_READY && sel == i && issue_ready) mst[i] = M_ISSUED;
      else if (mst[i] == M_ISSUED && cdb_valid && cdb_rs_id == 5'(i)) mst[i] = M_FREE;
    end
    if (dispatch_valid && fr >= 0) begin
      mp1[fr] = dispatch_op1_valid || (cdb_valid && cdb_rs_id == dispatch_op1_tag);
      mp2[fr] = dispatch_op2_valid || (cdb_valid && cdb_rs_id == dispatch_op2_tag);
      m1[fr] = dispatch_op1_valid ? dispatch_op1_value : cdb_result;
      m2[fr] = dispatch_op2_valid ? dispatch_op2_value : cdb_result;
      mt1[fr] = dispatch_op1_tag; mt2[fr] = dispatch_op2_tag;
      mad[fr] = dispatch_result_reg_addr; mc[fr] = dispatch_control;
      mst[fr] = (mp1[fr] && mp2[fr]) ? M_READY : M_WAIT;
    end
    lock = (sel >= 0 && !issue_ready) ? sel : -1;
  endtask
  initial begin
    r(1, 32'hF0F0F0F0, 1, 0, 32'hFF00FF00, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 32'hF0F0F0F0, 32'hFF00FF00);
    r(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    r(1, 32'h11111111, 1, 0, 0, 0, 7, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    r(0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h12345678, 1, 1, 0, 0, 0, 0);
    r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 32'h11111111, 32'h12345678);
    r(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    r(1, 0, 0, 9, 32'h0000FFFF, 1, 0, 1, 9, 32'hDEADBEEF, 1, 1, 0, 0, 0, 0);
    r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 32'hDEADBEEF, 32'h0000FFFF);
    r(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    r(1, 32'h100, 1, 0, 32'h200, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    r(1, 32'h101, 1, 0, 32'h201, 1, 0, 0, 0, 0, 1, 1, 1, 0, 32'h100, 32'h200);
    r(1, 32'h102, 1, 0, 32'h202, 1, 0, 0, 0, 0, 1, 1, 1, 1, 32'h101, 32'h201);
    r(1, 32'h103, 1, 0, 32'h203, 1, 0, 0, 0, 0, 1, 1, 1, 2, 32'h102, 32'h202);
    r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3, 32'h103, 32'h203);
    r(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0, 0, 0, 0, 0);
    r(1, 32'hE1, 1, 0, 32'hE2, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 32'hE1, 32'hE2);
    r(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    r(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0);
    r(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 1, 0, 0, 0, 0);
    r(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 1, 0, 0, 0, 0);
    r(1, 0, 0, 21, 32'hC0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    r(1, 0, 0, 21, 32'hC1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    r(1, 0, 0, 21, 32'hC2, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    r(1, 32'hA3, 1, 0, 32'hB3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    r(0, 0, 0, 0, 0, 0, 0, 1, 21, 32'h55, 0, 0, 1, 3, 32'hA3, 32'hB3);
    r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'hA3, 32'hB3);
    r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3, 32'hA3, 32'hB3);
    r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h55, 32'hC0);
    r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h55, 32'hC0);
    r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h55, 32'hC1);
    dispatch_result_reg_addr = 5'd3;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("reset issue_valid", issue_valid, 0);
    chk("reset dispatch_ready", dispatch_ready, 1);
    chk("reset issue_op1", issue_op1, 0);
    chk("reset issue_rs_id", issue_rs_id, 0);
    foreach (tab[k]) begin
      @(negedge clk);
      dispatch_valid = tab[k].dv;
      dispatch_op1_value = tab[k].o1; dispatch_op1_valid = tab[k].p1; dispatch_op1_tag = tab[k].t1;
      dispatch_op2_value = tab[k].o2; dispatch_op2_valid = tab[k].p2; dispatch_op2_tag = tab[k].t2;
      cdb_valid = tab[k].cv; cdb_rs_id = tab[k].ct; cdb_result = tab[k].cr;
      issue_ready = tab[k].ir;
      #1;
      chk($sformatf("row%0d dispatch_ready", k), dispatch_ready, tab[k].xdr);
      chk($sformatf("row%0d issue_valid", k), issue_valid, tab[k].xiv);
      if (tab[k].xiv) begin
        chk($sformatf("row%0d issue_rs_id", k), issue_rs_id, tab[k].xid);
        chk($sformatf("row%0d issue_op1", k), issue_op1, tab[k].xo1);
        chk($sformatf("row%0d issue_op2", k), issue_op2, tab[k].xo2);
      end
    end
    @(negedge clk);
    idle();
    rst = 1;
    @(negedge clk);
    rst = 0;
    cdb_valid = 1; cdb_rs_id = 3; cdb_result = 32'hFF;
    #1;
    chk("midreset issue_valid", issue_valid, 0);
    chk("midreset dispatch_ready", dispatch_ready, 1);
    chk("midreset issue_op1", issue_op1, 0);
    @(negedge clk);
    idle();
    #1;
    chk("late cdb issue_valid", issue_valid, 0);
    chk("late cdb dispatch_ready", dispatch_ready, 1);
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      dispatch_valid = $urandom_range(0, 1);
      dispatch_op1_value = $urandom; dispatch_op2_value = $urandom;
      dispatch_op1_valid = $urandom_range(0, 2) != 0;
      dispatch_op2_valid = $urandom_range(0, 2) != 0;
      dispatch_op1_tag = 5'($urandom_range(0, 5));
      dispatch_op2_tag = 5'($urandom_range(0, 5));
      dispatch_control = log_decode_t'($urandom_range(0, 7));
      dispatch_result_reg_addr = 5'($urandom);
      cdb_valid = $urandom_range(0, 1);
      cdb_rs_id = 5'($urandom_range(0, 5));
      cdb_result = $urandom;
      issue_ready = $urandom_range(0, 3) != 0;
      #1;
      model_step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
